// File: rtl/store_aligner.sv
// store_aligner: turns one store request into one or two word-aligned,
// little-endian write beats with byte enables. A store that straddles a word
// boundary is split into two consecutive beats. The request side is
// back-pressured until the last beat has been accepted.
module store_aligner #(
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              busy,
  output logic              is_misaligned,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(3'd4);

  state_t state_r, state_nx_s;

  // Request decode
  logic              op_valid_s;
  logic [2:0]        size_s;
  logic [3:0]        mask_s;
  logic [1:0]        off_s;
  logic              split_s;
  logic [ADDR_W-1:0] base_s;
  logic [31:0]       wdata1_s;
  logic [31:0]       wdata2_s;
  logic [7:0]        be_wide_s;
  logic [3:0]        be1_s;
  logic [3:0]        be2_s;

  // Handshakes (only count with the clock enable high)
  logic accept_s;
  logic hs_s;

  // Output and second-beat holding registers
  logic              mem_valid_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic [3:0]        mem_be_r;
  logic              busy_r;
  logic              mis_r;
  logic              done_r;
  logic              split_r;
  logic [ADDR_W-1:0] b2_addr_r;
  logic [31:0]       b2_wdata_r;
  logic [3:0]        b2_be_r;

  // Decode opcode class and compute both beats' lane placement up front
  always_comb begin
    op_valid_s = 1'b0;
    size_s     = 3'd0;
    mask_s     = 4'b0000;
    case (opcode)
      5'd3, 5'd4, 5'd5: begin
        op_valid_s = 1'b1;
        size_s     = 3'd4;
        mask_s     = 4'b1111;
      end
      5'd6, 5'd7, 5'd8: begin
        op_valid_s = 1'b1;
        size_s     = 3'd2;
        mask_s     = 4'b0011;
      end
      5'd9, 5'd10, 5'd11: begin
        op_valid_s = 1'b1;
        size_s     = 3'd1;
        mask_s     = 4'b0001;
      end
      default: begin
        op_valid_s = 1'b0;
        size_s     = 3'd0;
        mask_s     = 4'b0000;
      end
    endcase
    off_s     = addr[1:0];
    // off+size never exceeds 7, so 3 bits hold the sum
    split_s   = op_valid_s && (({1'b0, off_s} + size_s) > 3'd4);
    base_s    = {addr[ADDR_W-1:2], 2'b00};
    wdata1_s  = data << {off_s, 3'b000};
    // Shift of 32 (off=0) yields zero; that beat is never issued anyway
    wdata2_s  = data >> (6'd32 - {1'b0, off_s, 3'b000});
    be_wide_s = {4'b0000, mask_s} << off_s;
    be1_s     = be_wide_s[3:0];
    be2_s     = mask_s >> (3'd4 - {1'b0, off_s});
  end

  assign accept_s = req_valid && (state_r == ST_IDLE) && clk_en;
  assign hs_s     = mem_valid_r && mem_ready && clk_en;

  // Next-state logic for the beat sequencer
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && op_valid_s) begin
          state_nx_s = ST_BEAT1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BEAT1: begin
        if (hs_s) begin
          if (split_r && SPLIT_EN) begin
            state_nx_s = ST_BEAT2;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_BEAT1;
        end
      end
      ST_BEAT2: begin
        if (hs_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_BEAT2;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register; clk_en is already folded into the handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Beat fields, status flags and the latched second beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0000_0000;
      mem_be_r    <= 4'b0000;
      busy_r      <= 1'b0;
      mis_r       <= 1'b0;
      done_r      <= 1'b0;
      split_r     <= 1'b0;
      b2_addr_r   <= '0;
      b2_wdata_r  <= 32'h0000_0000;
      b2_be_r     <= 4'b0000;
    end else if (clk_en) begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            mis_r <= split_s;
            if (op_valid_s) begin
              mem_valid_r <= 1'b1;
              mem_addr_r  <= base_s;
              mem_wdata_r <= wdata1_s;
              mem_be_r    <= be1_s;
              busy_r      <= 1'b1;
              split_r     <= split_s;
              b2_addr_r   <= base_s + WORD_STEP;
              b2_wdata_r  <= wdata2_s;
              b2_be_r     <= be2_s;
            end
          end
        end
        ST_BEAT1: begin
          if (hs_s) begin
            if (split_r && SPLIT_EN) begin
              mem_addr_r  <= b2_addr_r;
              mem_wdata_r <= b2_wdata_r;
              mem_be_r    <= b2_be_r;
            end else begin
              mem_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end
          end
        end
        ST_BEAT2: begin
          if (hs_s) begin
            mem_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
          end
        end
        default: begin
          mem_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = (state_r == ST_IDLE);
  assign mem_valid     = mem_valid_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;
  assign mem_be        = mem_be_r;
  assign busy          = busy_r;
  assign is_misaligned = mis_r;
  assign done          = done_r;

endmodule
